// File: rtl/cl_pkg.sv
// Shared constants, trailer layout and FSM encoding for the Camera Link frame packer.
package cl_pkg;
   localparam int OUT_W  = 128;
   localparam int IN_W   = 80;
   localparam int ACC_W  = OUT_W + IN_W;
   localparam int FILL_W = 7;

   localparam logic [15:0] HDR_MAGIC_DEF = 16'hF5A0;
   localparam logic [15:0] TRL_MAGIC_DEF = 16'hF5AF;
   localparam int          MAX_LINES_DEF = 4096;

   localparam int TAG_LSB   = 112;
   localparam int FC_LSB    = 96;
   localparam int LINES_LSB = 80;
   localparam int BEATS_LSB = 32;
   localparam int OVF_BIT   = 0;

   typedef enum logic [2:0] {
      ST_SYNC,
      ST_IDLE,
      ST_HEADER,
      ST_ACTIVE,
      ST_FLUSH,
      ST_TRAILER
   } state_e;

   function automatic logic [OUT_W-1:0] mk_header(input logic [15:0] magic,
                                                  input logic [15:0] fc);
      logic [OUT_W-1:0] w;
      w = '0;
      w[TAG_LSB +: 16] = magic;
      w[FC_LSB +: 16]  = fc;
      return w;
   endfunction

   function automatic logic [OUT_W-1:0] mk_trailer(input logic [15:0] magic,
                                                   input logic [15:0] fc,
                                                   input logic [15:0] lines,
                                                   input logic [31:0] beats,
                                                   input logic        ovf);
      logic [OUT_W-1:0] w;
      w = '0;
      w[TAG_LSB +: 16]   = magic;
      w[FC_LSB +: 16]    = fc;
      w[LINES_LSB +: 16] = lines;
      w[BEATS_LSB +: 32] = beats;
      w[OVF_BIT]         = ovf;
      return w;
   endfunction
endpackage

// File: rtl/cl_gearbox_80to128.sv
// 80-to-128 bit gearbox: appends each pushed beat above the current fill and
// releases the low 128 bits in the same cycle the fill crosses 128.
module cl_gearbox_80to128
   import cl_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [IN_W-1:0]  din,
   input  logic             flush,
   output logic [OUT_W-1:0] dout,
   output logic             dout_vld,
   output logic             pending
);
   localparam logic [FILL_W-1:0] SPILL = FILL_W'(OUT_W - IN_W);

   logic [ACC_W-1:0]  acc;
   logic [ACC_W-1:0]  merged;
   logic [FILL_W-1:0] fill;
   logic              full;

   assign merged  = acc | ({{OUT_W{1'b0}}, din} << fill);
   assign full    = push && (fill >= SPILL);
   assign pending = |fill;

   // Bits above the fill are always zero, so a flush word comes out zero-padded.
   always_comb begin
      dout     = full ? merged[OUT_W-1:0] : acc[OUT_W-1:0];
      dout_vld = full || (flush && pending);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc  <= '0;
         fill <= '0;
      end else if (push) begin
         if (full) begin
            acc  <= {{OUT_W{1'b0}}, merged[ACC_W-1:OUT_W]};
            fill <= fill - SPILL;
         end else begin
            acc  <= merged;
            fill <= fill + FILL_W'(IN_W);
         end
      end else if (flush) begin
         acc  <= '0;
         fill <= '0;
      end
   end
endmodule

// File: rtl/cl_frame_packer.sv
// Frames FVAL/LVAL-qualified 80-bit pixel beats into header/data/trailer 128-bit
// words; the camera cannot stall, so a busy output register drops words.
module cl_frame_packer
   import cl_pkg::*;
#(
   parameter int          MAX_LINES = MAX_LINES_DEF,
   parameter logic [15:0] HDR_MAGIC = HDR_MAGIC_DEF,
   parameter logic [15:0] TRL_MAGIC = TRL_MAGIC_DEF
) (
   input  logic             cl_x_pclk,
   input  logic             reset,
   input  logic             cl_fval,
   input  logic             cl_lval,
   input  logic [IN_W-1:0]  cl_data,
   output logic [OUT_W-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_last,
   output logic [15:0]      frame_count,
   output logic             overflow,
   output logic [15:0]      drop_count
);
   localparam logic [15:0] LINES_SAT = 16'(MAX_LINES);

   state_e           state, state_nx;
   logic             fval_d, lval_d;
   logic [15:0]      lines;
   logic [31:0]      beats;
   logic             ovf_frame;
   logic             beat, flush;
   logic             gb_vld, gb_pending;
   logic [OUT_W-1:0] gb_dout;
   logic             emit, emit_last, drop;
   logic [OUT_W-1:0] emit_data;

   assign beat  = (state == ST_ACTIVE) && cl_fval && cl_lval;
   assign flush = (state == ST_FLUSH);
   assign drop  = emit && out_valid && !out_ready;

   cl_gearbox_80to128 u_gb (
      .clk      (cl_x_pclk),
      .reset    (reset),
      .push     (beat),
      .din      (cl_data),
      .flush    (flush),
      .dout     (gb_dout),
      .dout_vld (gb_vld),
      .pending  (gb_pending)
   );

   always_ff @(posedge cl_x_pclk) begin
      if (reset) state <= ST_SYNC;
      else       state <= state_nx;
   end

   // A rising edge seen in FLUSH/TRAILER leaves fval_d high in IDLE, so that frame is skipped.
   always_comb begin
      state_nx  = state;
      emit      = 1'b0;
      emit_last = 1'b0;
      emit_data = '0;
      case (state)
         ST_SYNC:   if (!cl_fval) state_nx = ST_IDLE;
         ST_IDLE:   if (cl_fval && !fval_d) state_nx = ST_HEADER;
         ST_HEADER: begin
            emit      = 1'b1;
            emit_data = mk_header(HDR_MAGIC, frame_count);
            state_nx  = ST_ACTIVE;
         end
         ST_ACTIVE: begin
            emit      = gb_vld;
            emit_data = gb_dout;
            if (!cl_fval) state_nx = gb_pending ? ST_FLUSH : ST_TRAILER;
         end
         ST_FLUSH: begin
            emit      = gb_vld;
            emit_data = gb_dout;
            state_nx  = ST_TRAILER;
         end
         ST_TRAILER: begin
            emit      = 1'b1;
            emit_last = 1'b1;
            emit_data = mk_trailer(TRL_MAGIC, frame_count, lines, beats, ovf_frame);
            state_nx  = ST_IDLE;
         end
         default:   state_nx = ST_SYNC;
      endcase
   end

   always_ff @(posedge cl_x_pclk) begin
      if (reset) begin
         fval_d      <= 1'b0;
         lval_d      <= 1'b0;
         out_data    <= '0;
         out_valid   <= 1'b0;
         out_last    <= 1'b0;
         frame_count <= '0;
         overflow    <= 1'b0;
         drop_count  <= '0;
         lines       <= '0;
         beats       <= '0;
         ovf_frame   <= 1'b0;
      end else begin
         fval_d <= cl_fval;
         lval_d <= cl_lval;

         if (emit && !drop) begin
            out_data  <= emit_data;
            out_valid <= 1'b1;
            out_last  <= emit_last;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end

         if (drop) begin
            overflow <= 1'b1;
            if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
         end

         // A dropped header still marks the new frame as lossy.
         if (state == ST_HEADER) begin
            lines     <= '0;
            beats     <= '0;
            ovf_frame <= drop;
         end else begin
            if (drop) ovf_frame <= 1'b1;
            if (beat) beats <= beats + 32'd1;
            if (state == ST_ACTIVE && lval_d && !cl_lval && lines != LINES_SAT)
               lines <= lines + 16'd1;
         end

         if (state == ST_TRAILER) frame_count <= frame_count + 16'd1;
      end
   end
endmodule

// File: tb/tb_cl_frame_packer.sv
// Directed bench for cl_frame_packer: table of frame shapes checked against a
// bit-stream model, plus hand sequences for byte order, backpressure, reset and gaps.
module tb_cl_frame_packer;
   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         cl_fval = 1'b0;
   logic         cl_lval = 1'b0;
   logic [79:0]  cl_data = '0;
   logic         out_ready = 1'b1;
   logic [127:0] out_data;
   logic         out_valid, out_last, overflow;
   logic [15:0]  frame_count, drop_count;

   always #5 clk = ~clk;

   cl_frame_packer dut (
      .cl_x_pclk   (clk),
      .reset       (reset),
      .cl_fval     (cl_fval),
      .cl_lval     (cl_lval),
      .cl_data     (cl_data),
      .out_data    (out_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_last    (out_last),
      .frame_count (frame_count),
      .overflow    (overflow),
      .drop_count  (drop_count)
   );

   typedef struct {
      int nl;
      int nb;
      int nwords;
      bit has_flush;
   } vec_t;

   int           n_chk = 0;
   int           n_fail = 0;
   int           seed = 0;
   logic [15:0]  exp_fc = '0;
   logic [127:0] cap_q[$];
   logic         cap_l[$];
   logic [127:0] exp_q[$];
   logic         exp_l[$];
   bit           bits_q[$];
   vec_t         vt[5];

   // Accepted words are recorded on the falling edge, ahead of the accepting edge.
   always @(negedge clk)
      if (!reset && out_valid && out_ready) begin
         cap_q.push_back(out_data);
         cap_l.push_back(out_last);
      end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [79:0] pix(input int s);
      logic [79:0] d;
      for (int i = 0; i < 10; i++) d[i*8 +: 8] = 8'(s * 7 + i * 13 + 1);
      return d;
   endfunction

   task automatic clear_q();
      cap_q.delete();
      cap_l.delete();
      exp_q.delete();
      exp_l.delete();
      bits_q.delete();
   endtask

   task automatic m_header(input logic [15:0] fc);
      exp_q.push_back({16'hF5A0, fc, 96'h0});
      exp_l.push_back(1'b0);
   endtask

   task automatic m_beat(input logic [79:0] d, input bit keep);
      logic [127:0] w;
      for (int i = 0; i < 80; i++) bits_q.push_back(d[i]);
      if (bits_q.size() >= 128) begin
         for (int i = 0; i < 128; i++) w[i] = bits_q.pop_front();
         if (keep) begin
            exp_q.push_back(w);
            exp_l.push_back(1'b0);
         end
      end
   endtask

   task automatic m_end(input logic [15:0] fc, input logic [15:0] ln,
                        input logic [31:0] bt, input bit ovf);
      logic [127:0] w;
      int           n;
      n = bits_q.size();
      if (n > 0) begin
         w = '0;
         for (int i = 0; i < n; i++) w[i] = bits_q.pop_front();
         exp_q.push_back(w);
         exp_l.push_back(1'b0);
      end
      w = '0;
      w[127:112] = 16'hF5AF;
      w[111:96]  = fc;
      w[95:80]   = ln;
      w[63:32]   = bt;
      w[0]       = ovf;
      exp_q.push_back(w);
      exp_l.push_back(1'b1);
   endtask

   task automatic frame_start();
      cl_fval = 1'b1;
      tick();
      chk("hdr_lat1_valid", 128'(out_valid), 128'(0));
      tick();
      chk("hdr_lat2_valid", 128'(out_valid), 128'(1));
   endtask

   task automatic frame_lines(input int nl, input int nb, input bit keep);
      for (int l = 0; l < nl; l++) begin
         for (int b = 0; b < nb; b++) begin
            cl_lval = 1'b1;
            cl_data = pix(seed);
            m_beat(pix(seed), keep);
            seed++;
            tick();
         end
         cl_lval = 1'b0;
         cl_data = '0;
         tick();
         tick();
      end
   endtask

   task automatic frame_end(input int gap);
      cl_fval = 1'b0;
      cl_lval = 1'b0;
      repeat (gap) tick();
   endtask

   task automatic cmp_words(input string name);
      chk({name, "_nwords"}, 128'(cap_q.size()), 128'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
         chk($sformatf("%s_w%0d", name, i), cap_q[i], exp_q[i]);
         chk($sformatf("%s_last%0d", name, i), 128'(cap_l[i]), 128'(exp_l[i]));
      end
   endtask

   initial begin
      // frame shapes with hand-computed word totals (header + data + flush? + trailer)
      vt[0] = '{nl: 2, nb: 8, nwords: 12, has_flush: 1'b0};
      vt[1] = '{nl: 1, nb: 3, nwords: 4,  has_flush: 1'b1};
      vt[2] = '{nl: 3, nb: 5, nwords: 12, has_flush: 1'b1};
      vt[3] = '{nl: 1, nb: 1, nwords: 3,  has_flush: 1'b1};
      vt[4] = '{nl: 1, nb: 8, nwords: 7,  has_flush: 1'b0};

      repeat (3) tick();
      chk("rst_out_data", out_data, 128'(0));
      chk("rst_out_valid", 128'(out_valid), 128'(0));
      chk("rst_out_last", 128'(out_last), 128'(0));
      chk("rst_frame_count", 128'(frame_count), 128'(0));
      chk("rst_overflow", 128'(overflow), 128'(0));
      chk("rst_drop_count", 128'(drop_count), 128'(0));
      reset = 1'b0;
      repeat (2) tick();

      for (int v = 0; v < 5; v++) begin
         clear_q();
         m_header(exp_fc);
         frame_start();
         frame_lines(vt[v].nl, vt[v].nb, 1'b1);
         frame_end(6);
         m_end(exp_fc, 16'(vt[v].nl), 32'(vt[v].nl * vt[v].nb), 1'b0);
         cmp_words($sformatf("vec%0d", v));
         chk($sformatf("vec%0d_total", v), 128'(cap_q.size()), 128'(vt[v].nwords));
         if (vt[v].has_flush)
            chk($sformatf("vec%0d_flush_tag", v), 128'(cap_q[cap_q.size()-2][127:112]), 128'(0));
         exp_fc = exp_fc + 16'd1;
         chk($sformatf("vec%0d_frame_count", v), 128'(frame_count), 128'(exp_fc));
      end

      // byte order: taps A..J = 01..0A, then an all-ones beat
      clear_q();
      frame_start();
      cl_lval = 1'b1;
      cl_data = 80'h0A090807060504030201;
      tick();
      cl_data = '1;
      tick();
      cl_lval = 1'b0;
      cl_data = '0;
      tick();
      tick();
      frame_end(6);
      chk("bo_nwords", 128'(cap_q.size()), 128'(4));
      chk("bo_word0", cap_q[1], {48'hFFFF_FFFF_FFFF, 80'h0A090807060504030201});
      chk("bo_flush", cap_q[2], {96'h0, 32'hFFFF_FFFF});
      chk("bo_trailer", cap_q[3], {16'hF5AF, exp_fc, 16'd1, 16'd0, 32'd2, 32'd0});
      exp_fc = exp_fc + 16'd1;

      // backpressure across a whole 16-beat frame: header held, 10 data + trailer dropped
      clear_q();
      out_ready = 1'b0;
      frame_start();
      frame_lines(2, 8, 1'b0);
      frame_end(6);
      chk("bp_held_valid", 128'(out_valid), 128'(1));
      chk("bp_held_header", out_data, {16'hF5A0, exp_fc, 96'h0});
      chk("bp_drop_count", 128'(drop_count), 128'(11));
      chk("bp_overflow", 128'(overflow), 128'(1));
      exp_fc = exp_fc + 16'd1;
      chk("bp_frame_count", 128'(frame_count), 128'(exp_fc));
      out_ready = 1'b1;
      tick();
      tick();
      chk("bp_drained", 128'(out_valid), 128'(0));

      // backpressure only during the data; trailer seen after ready returns
      clear_q();
      m_header(exp_fc);
      frame_start();
      out_ready = 1'b0;
      frame_lines(2, 8, 1'b0);
      out_ready = 1'b1;
      frame_end(6);
      m_end(exp_fc, 16'd2, 32'd16, 1'b1);
      cmp_words("bp2");
      chk("bp2_drop_count", 128'(drop_count), 128'(21));
      exp_fc = exp_fc + 16'd1;

      // reset while FVAL is high: nothing until a fresh FVAL rise
      clear_q();
      frame_start();
      cl_lval = 1'b1;
      repeat (3) begin cl_data = pix(seed); seed++; tick(); end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      clear_q();
      repeat (5) begin cl_data = pix(seed); seed++; tick(); end
      cl_lval = 1'b0;
      tick();
      tick();
      chk("mrst_valid", 128'(out_valid), 128'(0));
      chk("mrst_frame_count", 128'(frame_count), 128'(0));
      chk("mrst_overflow", 128'(overflow), 128'(0));
      chk("mrst_drop_count", 128'(drop_count), 128'(0));
      frame_end(4);
      chk("mrst_no_words", 128'(cap_q.size()), 128'(0));
      exp_fc = '0;
      clear_q();
      m_header(exp_fc);
      frame_start();
      frame_lines(1, 8, 1'b1);
      frame_end(6);
      m_end(exp_fc, 16'd1, 32'd8, 1'b0);
      cmp_words("mrst_next");
      exp_fc = exp_fc + 16'd1;

      // stray LVAL with FVAL low
      clear_q();
      cl_lval = 1'b1;
      repeat (3) begin cl_data = pix(seed); seed++; tick(); end
      cl_lval = 1'b0;
      repeat (4) tick();
      chk("stray_no_words", 128'(cap_q.size()), 128'(0));
      chk("stray_valid", 128'(out_valid), 128'(0));

      // short gap: FVAL re-rises one cycle after falling, so the second frame is skipped
      clear_q();
      m_header(exp_fc);
      frame_start();
      frame_lines(1, 8, 1'b1);
      cl_fval = 1'b0;
      tick();
      cl_fval = 1'b1;
      tick();
      cl_lval = 1'b1;
      repeat (8) begin cl_data = pix(seed); seed++; tick(); end
      cl_lval = 1'b0;
      tick();
      tick();
      frame_end(8);
      m_end(exp_fc, 16'd1, 32'd8, 1'b0);
      cmp_words("gap");
      exp_fc = exp_fc + 16'd1;
      chk("gap_frame_count", 128'(frame_count), 128'(exp_fc));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
